soc_system_fpga_button_pio: RTL

// - Avalon-MM slave input PIO for push-buttons/switches; the read-side counterpart of the LED output PIO.
// - Synchronises and debounces WIDTH async inputs, captures edges, and raises a maskable IRQ to the HPS.
// - Sits on the lightweight HPS-to-FPGA bridge beside the LED PIO.

---
 rtl/soc_system_fpga_button_pio.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/soc_system_fpga_button_pio.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_fpga_button_pio
// Purpose  : Avalon-MM input PIO for push-buttons/switches. Synchronises and
//            debounces raw pins, captures edges and raises a maskable IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module soc_system_fpga_button_pio #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_MASK      = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_MASKSET = 3'd4;
    localparam logic [2:0] ADDR_MASKCLR = 3'd5;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_strobe;
    logic             unused_wdata;

    // Upper writedata bits are architecturally ignored.
    assign unused_wdata = &{1'b0, writedata};

    // Two-flop synchroniser input feeds.
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
    end

    // Synchroniser registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            logic deb_q, deb_d;

            // Bypass: debounced level is just the synchronised level, one cycle later.
            always_comb deb_d = sync2_q[i];

            // Debounced level register.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) deb_q <= 1'b0;
                else          deb_q <= deb_d;
            end

            assign debounced[i] = deb_q;
        end else begin : g_debounce
            localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             deb_q, deb_d;

            // Count consecutive cycles of disagreement; accept the new level on the last one.
            always_comb begin
                cnt_d = cnt_q;
                deb_d = deb_q;
                if (sync2_q[i] == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    deb_d = sync2_q[i];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Debounce counter and accepted level.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    deb_q <= deb_d;
                end
            end

            assign debounced[i] = deb_q;
        end
    end

    assign wr_strobe = chipselect & ~write_n;

    // Edge selection between the debounced level and its one-cycle-old copy.
    always_comb begin
        case (EDGE_TYPE)
            0:       edge_det = debounced & ~prev_q;
            1:       edge_det = ~debounced & prev_q;
            default: edge_det = debounced ^ prev_q;
        endcase
    end

    // Register-file next state; a new edge overrides a simultaneous W1C clear.
    always_comb begin
        prev_d         = debounced;
        irq_mask_d     = irq_mask_q;
        edge_capture_d = edge_capture_q;
        if (wr_strobe) begin
            case (address)
                ADDR_IRQMASK: irq_mask_d     = writedata[WIDTH-1:0];
                ADDR_EDGECAP: edge_capture_d = edge_capture_q & ~writedata[WIDTH-1:0];
                ADDR_MASKSET: irq_mask_d     = irq_mask_q | writedata[WIDTH-1:0];
                ADDR_MASKCLR: irq_mask_d     = irq_mask_q & ~writedata[WIDTH-1:0];
                default: ;
            endcase
        end
        edge_capture_d = edge_capture_d | edge_det;
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = debounced;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_capture_q;
            default: ;
        endcase
    end

    // Edge history, capture, mask and read data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q         <= '0;
            edge_capture_q <= '0;
            irq_mask_q     <= RESET_MASK;
            readdata_q     <= '0;
        end else begin
            prev_q         <= prev_d;
            edge_capture_q <= edge_capture_d;
            irq_mask_q     <= irq_mask_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule
`default_nettype wire
